// File: rtl/qeciphy_faw_lock_ctrl.sv
// Frame Alignment Word lock controller: hunts for the FAW, requests bitslips when
// none is found within a frame, verifies periodicity and tracks lock.
package qeciphy_pkg;

  function automatic logic is_faw(input logic [63:0] data, input logic valid);
    return valid && (data[39:32] == 8'hCB) && (data[7:0] == 8'hBC);
  endfunction

endpackage

module qeciphy_faw_lock_ctrl #(
  parameter int FAW_PERIOD   = 64,
  parameter int VERIFY_COUNT = 3,
  parameter int MISS_LIMIT   = 4,
  parameter int SLIP_WAIT    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        align_en,
  input  logic [63:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_slip,
  output logic        locked,
  output logic        faw_strobe,
  output logic [1:0]  state,
  output logic [7:0]  slip_count
);

  localparam int POS_W   = $clog2(FAW_PERIOD) + 1;
  localparam int MATCH_W = $clog2(VERIFY_COUNT) + 1;
  localparam int MISS_W  = $clog2(MISS_LIMIT) + 1;
  localparam int WAIT_W  = $clog2(SLIP_WAIT) + 1;

  localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(FAW_PERIOD);
  localparam logic [POS_W-1:0]   HUNT_LAST  = POS_W'(FAW_PERIOD - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(VERIFY_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(MISS_LIMIT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [POS_W-1:0]     hunt_q, hunt_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [7:0]           slip_cnt_q, slip_cnt_d;
  logic                 slip_q, slip_d;
  logic                 strobe_q, strobe_d;
  logic                 locked_q, locked_d;

  logic faw_hit;
  logic at_exp;

  assign faw_hit = qeciphy_pkg::is_faw(rx_data, rx_valid);
  // pos_q is the position of the word currently on rx_data relative to the anchor
  assign at_exp  = rx_valid && (pos_q == POS_LAST);

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      pos_q      <= '0;
      hunt_q     <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      wait_q     <= '0;
      slip_cnt_q <= '0;
      slip_q     <= 1'b0;
      strobe_q   <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      hunt_q     <= hunt_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      wait_q     <= wait_d;
      slip_cnt_q <= slip_cnt_d;
      slip_q     <= slip_d;
      strobe_q   <= strobe_d;
      locked_q   <= locked_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!align_en) begin
      state_d = ST_HUNT;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (faw_hit) begin
            state_d = ST_VERIFY;
          end else if (rx_valid && (hunt_q == HUNT_LAST)) begin
            state_d = ST_SLIP;
          end
        end
        ST_SLIP: begin
          if (wait_q == '0) state_d = ST_HUNT;
        end
        ST_VERIFY: begin
          if (at_exp) begin
            if (!faw_hit)                     state_d = ST_HUNT;
            else if (match_q == MATCH_LAST)   state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (at_exp && !faw_hit && (miss_q == MISS_LAST)) state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Counter and output logic
  always_comb begin
    pos_d      = pos_q;
    hunt_d     = hunt_q;
    match_d    = match_q;
    miss_d     = miss_q;
    wait_d     = wait_q;
    slip_cnt_d = slip_cnt_q;
    slip_d     = 1'b0;
    strobe_d   = 1'b0;
    locked_d   = (state_d == ST_LOCKED);

    if (!align_en) begin
      pos_d   = '0;
      hunt_d  = '0;
      match_d = '0;
      miss_d  = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (faw_hit) begin
            pos_d    = POS_W'(1);
            hunt_d   = '0;
            strobe_d = 1'b1;
          end else if (rx_valid) begin
            if (hunt_q == HUNT_LAST) begin
              hunt_d     = '0;
              slip_d     = 1'b1;
              wait_d     = WAIT_LOAD;
              slip_cnt_d = (slip_cnt_q == 8'hFF) ? slip_cnt_q : slip_cnt_q + 8'd1;
            end else begin
              hunt_d = hunt_q + POS_W'(1);
            end
          end
        end
        ST_SLIP: begin
          if (wait_q != '0) begin
            wait_d = wait_q - WAIT_W'(1);
          end else begin
            pos_d   = '0;
            hunt_d  = '0;
            match_d = '0;
            miss_d  = '0;
          end
        end
        ST_VERIFY: begin
          if (at_exp) begin
            pos_d = POS_W'(1);
            if (faw_hit) begin
              strobe_d = 1'b1;
              match_d  = (match_q == MATCH_LAST) ? '0 : match_q + MATCH_W'(1);
            end else begin
              match_d = '0;
              pos_d   = '0;
            end
          end else if (rx_valid) begin
            pos_d = pos_q + POS_W'(1);
          end
        end
        ST_LOCKED: begin
          if (at_exp) begin
            pos_d = POS_W'(1);
            if (faw_hit) begin
              strobe_d = 1'b1;
              miss_d   = '0;
            end else if (miss_q == MISS_LAST) begin
              miss_d = '0;
              pos_d  = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else if (rx_valid) begin
            pos_d = pos_q + POS_W'(1);
          end
        end
        default: begin
          pos_d = '0;
        end
      endcase
    end
  end

  assign state      = state_q;
  assign rx_slip    = slip_q;
  assign faw_strobe = strobe_q;
  assign locked     = locked_q;
  assign slip_count = slip_cnt_q;

endmodule
